// File: rtl/sound_pkg.sv
// Shared constants for the sound scheduler: event indices, FSM encoding,
// counter widths and the default tone tables.
package sound_pkg;

    localparam logic [1:0] EV_WALL   = 2'd0;
    localparam logic [1:0] EV_PADDLE = 2'd1;
    localparam logic [1:0] EV_BLOCK  = 2'd2;
    localparam logic [1:0] EV_LOST   = 2'd3;

    localparam int HP_W  = 17;
    localparam int MS_W  = 16;
    localparam int DUR_W = 9;

    localparam int DEF_MS_DIVIDER    = 40000;
    localparam int DEF_HALF_PERIOD_0 = 45455;
    localparam int DEF_HALF_PERIOD_1 = 30337;
    localparam int DEF_HALF_PERIOD_2 = 22727;
    localparam int DEF_HALF_PERIOD_3 = 90909;
    localparam int DEF_DURATION_0    = 30;
    localparam int DEF_DURATION_1    = 40;
    localparam int DEF_DURATION_2    = 50;
    localparam int DEF_DURATION_3    = 400;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Fixed priority: the highest set bit wins.
    function automatic logic [1:0] highest_event(input logic [3:0] v);
        logic [1:0] idx;
        idx = EV_WALL;
        if (v[3])      idx = EV_LOST;
        else if (v[2]) idx = EV_BLOCK;
        else if (v[1]) idx = EV_PADDLE;
        return idx;
    endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Request/status bundle between the game logic and the sound scheduler.
interface sound_scheduler_if;

    logic [3:0] sound_req;
    logic       sw_mute;
    logic       audio;
    logic       busy;
    logic [1:0] active_event;

    modport master (
        output sound_req,
        output sw_mute,
        input  audio,
        input  busy,
        input  active_event
    );

    modport slave (
        input  sound_req,
        input  sw_mute,
        output audio,
        output busy,
        output active_event
    );

endinterface

// File: rtl/sound_scheduler_tone_generator.sv
// Square-wave source: toggles every half_period clocks, starts on the high
// phase after restart and rests low while disabled.
module tone_generator
    import sound_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            restart,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] hp_cnt;
    logic [HP_W-1:0] hp_term;

    assign hp_term = half_period - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            hp_cnt <= '0;
            tone   <= 1'b0;
        end else if (restart) begin
            hp_cnt <= '0;
            tone   <= 1'b1;
        end else if (!enable) begin
            hp_cnt <= '0;
            tone   <= 1'b0;
        end else if (hp_cnt >= hp_term) begin
            hp_cnt <= '0;
            tone   <= ~tone;
        end else begin
            hp_cnt <= hp_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Prioritised one-voice sound scheduler: latches event requests, plays the
// most important one as a timed square wave, preempting or restarting as needed.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int MS_DIVIDER    = DEF_MS_DIVIDER,
    parameter int HALF_PERIOD_0 = DEF_HALF_PERIOD_0,
    parameter int HALF_PERIOD_1 = DEF_HALF_PERIOD_1,
    parameter int HALF_PERIOD_2 = DEF_HALF_PERIOD_2,
    parameter int HALF_PERIOD_3 = DEF_HALF_PERIOD_3,
    parameter int DURATION_0    = DEF_DURATION_0,
    parameter int DURATION_1    = DEF_DURATION_1,
    parameter int DURATION_2    = DEF_DURATION_2,
    parameter int DURATION_3    = DEF_DURATION_3
) (
    input  logic              clk,
    input  logic              reset,
    sound_scheduler_if.slave  bus
);

    localparam logic [HP_W-1:0] HP_TAB [4] = '{
        HP_W'(HALF_PERIOD_0), HP_W'(HALF_PERIOD_1),
        HP_W'(HALF_PERIOD_2), HP_W'(HALF_PERIOD_3)
    };
    localparam logic [DUR_W-1:0] DUR_TAB [4] = '{
        DUR_W'(DURATION_0), DUR_W'(DURATION_1),
        DUR_W'(DURATION_2), DUR_W'(DURATION_3)
    };
    localparam logic [MS_W-1:0] MS_TERM = MS_W'(MS_DIVIDER - 1);

    state_t           state, state_next;
    logic [3:0]       pending, pending_next;
    logic [3:0]       cand;
    logic [1:0]       active, hi_cand, hi_req;
    logic [1:0]       start_idx;
    logic             start;
    logic [MS_W-1:0]  ms_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [DUR_W-1:0] dur_term;
    logic             tick;
    logic             ev_done;
    logic             tone;

    assign cand     = pending | bus.sound_req;
    assign hi_cand  = highest_event(cand);
    assign hi_req   = highest_event(bus.sound_req);
    assign dur_term = DUR_TAB[active] - 1'b1;
    assign tick     = (ms_cnt >= MS_TERM);
    assign ev_done  = (state == PLAY) && tick && (dur_cnt >= dur_term);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            active  <= EV_WALL;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (start)
                active <= start_idx;
            else if (state_next == IDLE)
                active <= EV_WALL;
        end
    end

    // Next state: idle start, end-of-tone handoff, preempt or restart.
    always_comb begin
        state_next   = state;
        start        = 1'b0;
        start_idx    = EV_WALL;
        pending_next = cand;
        case (state)
            IDLE: begin
                if (cand != 4'b0) begin
                    start      = 1'b1;
                    start_idx  = hi_cand;
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (ev_done) begin
                    if (cand != 4'b0) begin
                        start     = 1'b1;
                        start_idx = hi_cand;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.sound_req != 4'b0 && hi_req >= active) begin
                    start     = 1'b1;
                    start_idx = hi_req;
                end
            end
            default: state_next = IDLE;
        endcase
        if (start)
            pending_next = cand & ~(4'b0001 << start_idx);
    end

    // Millisecond timebase; both counters stop at their terminal values.
    always_ff @(posedge clk) begin
        if (reset || start || state_next != PLAY) begin
            ms_cnt  <= '0;
            dur_cnt <= '0;
        end else if (tick) begin
            ms_cnt  <= '0;
            dur_cnt <= dur_cnt + 1'b1;
        end else begin
            ms_cnt  <= ms_cnt + 1'b1;
        end
    end

    tone_generator u_tone (
        .clk         (clk),
        .reset       (reset),
        .enable      (state_next == PLAY),
        .restart     (start),
        .half_period (HP_TAB[active]),
        .tone        (tone)
    );

    assign bus.audio        = tone & ~bus.sw_mute;
    assign bus.busy         = (state == PLAY);
    assign bus.active_event = active;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler with shortened tone/ms parameters.
module tb_sound_scheduler;

    localparam int MS_M = 4;
    localparam int HP_M [4]  = '{3, 4, 5, 6};
    localparam int DUR_M [4] = '{2, 2, 3, 4};

    logic clk;
    logic reset;

    sound_scheduler_if bus ();

    sound_scheduler #(
        .MS_DIVIDER    (MS_M),
        .HALF_PERIOD_0 (3),
        .HALF_PERIOD_1 (4),
        .HALF_PERIOD_2 (5),
        .HALF_PERIOD_3 (6),
        .DURATION_0    (2),
        .DURATION_1    (2),
        .DURATION_2    (3),
        .DURATION_3    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] sb [$];
    logic [3:0] sb_exp;

    // Reference state: elapsed clocks since the current tone started.
    logic       m_play;
    int         m_ev;
    int         m_el;
    logic [3:0] m_pend;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hi_bit(input logic [3:0] v);
        for (int i = 3; i > 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_start(input int ev, input logic [3:0] cand);
        m_play = 1'b1;
        m_ev   = ev;
        m_el   = 0;
        m_pend = cand & ~(4'b0001 << ev);
    endtask

    task automatic model_step(input logic [3:0] req, input logic mute, input logic rst);
        logic [3:0] cand;
        logic       aud;
        if (rst) begin
            m_play = 1'b0; m_ev = 0; m_el = 0; m_pend = 4'b0;
        end else begin
            cand = m_pend | req;
            if (!m_play) begin
                if (cand != 4'b0) m_start(hi_bit(cand), cand);
            end else if (m_el + 1 >= DUR_M[m_ev] * MS_M) begin
                if (cand != 4'b0) m_start(hi_bit(cand), cand);
                else begin
                    m_play = 1'b0; m_ev = 0; m_el = 0; m_pend = 4'b0;
                end
            end else if (req != 4'b0 && hi_bit(req) >= m_ev) begin
                m_start(hi_bit(req), cand);
            end else begin
                m_el++;
                m_pend = cand;
            end
        end
        aud = m_play && !mute && ((m_el / HP_M[m_ev]) % 2 == 0);
        sb.push_back({m_play, 2'(m_ev), aud});
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_exp = sb.pop_front();
            check("outputs{busy,ev,audio}",
                  int'({bus.busy, bus.active_event, bus.audio}), int'(sb_exp));
        end
    end

    task automatic step(input logic [3:0] req, input logic mute, input logic rst);
        bus.sound_req = req;
        bus.sw_mute   = mute;
        reset         = rst;
        @(posedge clk);
        model_step(req, mute, rst);
        @(negedge clk);
        #1;
        bus.sound_req = 4'b0;
    endtask

    int busy_cnt, aud_cnt, ev1_cnt;
    logic [7:0] pattern;
    logic [3:0] rreq;
    logic       rmute, rrst;

    initial begin
        bus.sound_req = 4'b0;
        bus.sw_mute   = 1'b0;
        reset         = 1'b1;
        m_play = 1'b0; m_ev = 0; m_el = 0; m_pend = 4'b0;

        // Reset state
        repeat (3) step(4'b0, 1'b0, 1'b1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_event", int'(bus.active_event), 0);
        check("reset_audio", int'(bus.audio), 0);

        // Single wall event: 3-clock half period, 8-clock duration
        step(4'b0001, 1'b0, 1'b0);
        check("wall_start_busy", int'(bus.busy), 1);
        check("wall_start_audio", int'(bus.audio), 1);
        pattern = {7'b0, bus.audio};
        busy_cnt = 1;
        for (int i = 1; i < 8; i++) begin
            step(4'b0, 1'b0, 1'b0);
            pattern = {pattern[6:0], bus.audio};
            busy_cnt += int'(bus.busy);
        end
        check("wall_audio_pattern", int'(pattern), 8'b11100011);
        for (int i = 0; i < 4; i++) begin
            step(4'b0, 1'b0, 1'b0);
            busy_cnt += int'(bus.busy);
        end
        check("wall_busy_len", busy_cnt, 8);
        check("wall_end_audio", int'(bus.audio), 0);

        // Simultaneous block+wall: block 12 clocks, then wall without idle
        step(4'b0101, 1'b0, 1'b0);
        check("multi_first_ev", int'(bus.active_event), 2);
        for (int i = 0; i < 11; i++) step(4'b0, 1'b0, 1'b0);
        check("multi_still_block", int'(bus.active_event), 2);
        step(4'b0, 1'b0, 1'b0);
        check("multi_handoff_busy", int'(bus.busy), 1);
        check("multi_handoff_ev", int'(bus.active_event), 0);
        check("multi_handoff_audio", int'(bus.audio), 1);
        repeat (10) step(4'b0, 1'b0, 1'b0);

        // Paddle preempted by ball-lost at its third clock
        step(4'b0010, 1'b0, 1'b0);
        repeat (2) step(4'b0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        check("preempt_ev", int'(bus.active_event), 3);
        check("preempt_audio", int'(bus.audio), 1);
        ev1_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0, 1'b0, 1'b0);
            if (bus.busy && bus.active_event == 2'd1) ev1_cnt++;
        end
        check("preempt_no_resume", ev1_cnt, 0);
        check("preempt_idle", int'(bus.busy), 0);

        // Block restarted at its fifth clock
        step(4'b0100, 1'b0, 1'b0);
        repeat (4) step(4'b0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("restart_audio", int'(bus.audio), 1);
        busy_cnt = 1;
        for (int i = 0; i < 15; i++) begin
            step(4'b0, 1'b0, 1'b0);
            busy_cnt += int'(bus.busy);
        end
        check("restart_busy_len", busy_cnt, 12);

        // Muted ball-lost: normal timing, silent pin
        step(4'b1000, 1'b1, 1'b0);
        busy_cnt = int'(bus.busy);
        aud_cnt  = int'(bus.audio);
        for (int i = 0; i < 19; i++) begin
            step(4'b0, 1'b1, 1'b0);
            busy_cnt += int'(bus.busy);
            aud_cnt  += int'(bus.audio);
        end
        check("mute_busy_len", busy_cnt, 16);
        check("mute_audio_high", aud_cnt, 0);

        // Reset mid-tone with pending requests, plus a request during reset
        step(4'b1000, 1'b0, 1'b0);
        repeat (3) step(4'b0, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0, 1'b0, 1'b1);
        check("midreset_outputs", int'({bus.busy, bus.active_event, bus.audio}), 0);
        step(4'b0001, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(4'b0, 1'b0, 1'b0);
            busy_cnt += int'(bus.busy);
        end
        check("midreset_pending_cleared", busy_cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rreq  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            rmute = ($urandom_range(0, 9) == 0);
            rrst  = ($urandom_range(0, 99) == 0);
            step(rreq, rmute, rrst);
        end
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter MS_DIVIDER, default 40000: clocks per 1 ms tick at 40 MHz.
REQ-002 Parameter HALF_PERIOD_0..3, defaults 45455 / 30337 / 22727 / 90909: tone half-period in clocks for wall, paddle, block and ball-lost events (440 / 659 / 880 / 220 Hz).
REQ-003 Parameter DURATION_0..3, defaults 30 / 40 / 50 / 400: tone length in ms per event.
REQ-004 CLK  input  1  system clock, 40 MHz; one clock domain.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 SOUND_REQ  input  4  one-cycle request pulses: bit0 wall, bit1 paddle, bit2 block, bit3 ball lost.
REQ-007 SW_MUTE  input  1  forces AUDIO low; scheduling continues.
REQ-008 AUDIO  output  1  square-wave audio to the pin driver.
REQ-009 BUSY  output  1  high while a tone is playing.
REQ-010 ACTIVE_EVENT  output  2  index of the playing event; 0 when idle.

Function
REQ-011 The block SHALL use fixed priority: bit3 > bit2 > bit1 > bit0.
REQ-012 The block SHALL latch every SOUND_REQ bit into a 4-bit pending register; a bit clears only when its event starts playing or is dropped.
REQ-013 The state machine SHALL have two states: IDLE and PLAY.
REQ-014 IDLE -> PLAY: one cycle after any pending bit or SOUND_REQ bit is set, the highest-priority event starts.
REQ-015 On start: BUSY=1, ACTIVE_EVENT=index, AUDIO=1 (high phase first), half-period counter and ms counters cleared.
REQ-016 AUDIO SHALL toggle every HALF_PERIOD_n clocks of the active event.
REQ-017 A ms tick SHALL occur every MS_DIVIDER clocks after start; the event ends on the cycle its tick count reaches DURATION_n.
REQ-018 At end: if any bit is pending, the highest pending event starts on the next cycle, with no silent gap beyond that cycle; otherwise the block goes to IDLE with AUDIO=0, BUSY=0, ACTIVE_EVENT=0.
REQ-019 A request of higher priority than the active event SHALL preempt it: the new event starts on the next cycle and the preempted event is discarded, not resumed.
REQ-020 A request equal to the active event SHALL restart it: counters clear and AUDIO=1 on the next cycle.
REQ-021 A lower-priority request SHALL remain pending until the active event ends.
REQ-022 Simultaneous multi-bit requests: the highest bit starts; the remaining bits stay pending.
REQ-023 AUDIO SHALL equal the internal tone AND NOT SW_MUTE, combinationally gated from a registered tone.
REQ-024 Counter widths: half-period 17 bits, ms divider 16 bits, duration 9 bits; counters saturate at their terminal compare and never wrap.

Reset
REQ-025 While RESET is high on a clock edge: state=IDLE, pending=0, all counters=0, tone=0, BUSY=0, ACTIVE_EVENT=0.
REQ-026 RESET asserted mid-tone SHALL silence AUDIO on the next cycle, and requests arriving while RESET is high SHALL be ignored.

Structure
REQ-027 Package sound_pkg SHALL hold the event index constants, the IDLE/PLAY state encoding, and the default half-period and duration tables.
REQ-028 A sub-module tone_generator (half-period counter plus toggle flop, with restart and half-period inputs) SHALL produce the raw tone.

Verification (bench overrides MS_DIVIDER=4, HALF_PERIOD_n=3/4/5/6, DURATION_n=2/2/3/4)
REQ-029 Reset, then pulse SOUND_REQ=0001 -> next cycle BUSY=1, ACTIVE_EVENT=0, AUDIO=1; AUDIO toggles every 3 clocks; BUSY falls after 8 clocks and AUDIO=0.
REQ-030 Pulse SOUND_REQ=0101 in one cycle -> event 2 plays for 12 clocks, then event 0 starts on the next cycle without entering IDLE.
REQ-031 Event 1 playing; at clock 3 pulse bit3 -> next cycle ACTIVE_EVENT=3 and AUDIO=1; event 1 never resumes.
REQ-032 Event 2 playing; at clock 5 pulse bit2 again -> counters restart and BUSY lasts 12 clocks from the restart.
REQ-033 SW_MUTE=1 during event 3 -> AUDIO stays 0 while BUSY and ACTIVE_EVENT follow the normal timing; RESET asserted mid-tone -> next cycle all outputs are 0 and the pending bits are cleared.
